// File: rtl/ts_pkg.sv
// Shared constants and FSM state type for the serial MPEG-TS deframer.
package ts_pkg;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  typedef enum logic [1:0] {
    HUNT,
    PKT,
    DROP
  } ts_rx_state_t;
endpackage

// File: rtl/ts_serial_deframer_if.sv
// Serial TS input plus framed byte output and counters of the deframer.
interface ts_serial_deframer_if;
  logic        ts_start;
  logic        ts_valid;
  logic        ts_data;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_sop;
  logic        byte_eop;
  logic        pkt_abort;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  // master: the deframer, which sources the byte stream
  modport master (
    input  ts_start, ts_valid, ts_data,
    output byte_data, byte_valid, byte_sop, byte_eop, pkt_abort, pkt_cnt, err_cnt
  );

  modport slave (
    output ts_start, ts_valid, ts_data,
    input  byte_data, byte_valid, byte_sop, byte_eop, pkt_abort, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/ts_serial_deframer.sv
// Serial MPEG-TS to framed byte stream with packet/error counters.
// Optional sync-byte check on byte 0 enabled by defining TS_SYNC_CHECK_EN.
module ts_serial_deframer
  import ts_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ts_serial_deframer_if.master  ts
);

  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);

  ts_rx_state_t r_state;
  ts_rx_state_t w_state_nxt;
  logic [6:0]   r_sh;
  logic [2:0]   r_bit_cnt;
  logic [7:0]   r_byte_cnt;
  logic [7:0]   w_byte_cnt_nxt;
  logic         r_start_q;
  logic [7:0]   r_byte_data;
  logic         r_byte_valid;
  logic         r_byte_sop;
  logic         r_byte_eop;
  logic         r_pkt_abort;
  logic [15:0]  r_pkt_cnt;
  logic [15:0]  r_err_cnt;

  logic         w_start_edge;
  logic         w_byte_done;
  logic [7:0]   w_byte;
  logic         w_sync_bad;
  logic         w_emit;
  logic         w_sop;
  logic         w_eop;
  logic         w_abort;
  logic         w_err_inc;
  logic         w_pkt_inc;

  // Only the 7 pending bits are stored; the completing bit joins combinationally.
  assign w_byte       = {r_sh, ts.ts_data};
  assign w_start_edge = ts.ts_valid & ts.ts_start & ~r_start_q;
  assign w_byte_done  = ts.ts_valid & ~w_start_edge & (r_bit_cnt == 3'd7);

`ifdef TS_SYNC_CHECK_EN
  assign w_sync_bad = (r_byte_cnt == '0) && (w_byte != TS_SYNC_BYTE);
`else
  assign w_sync_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_emit         = 1'b0;
    w_sop          = 1'b0;
    w_eop          = 1'b0;
    w_abort        = 1'b0;
    w_err_inc      = 1'b0;
    w_pkt_inc      = 1'b0;
    unique case (r_state)
      HUNT, DROP: begin
        if (w_start_edge) begin
          w_state_nxt    = PKT;
          w_byte_cnt_nxt = '0;
        end
      end
      PKT: begin
        if (w_start_edge) begin
          if (r_byte_cnt != '0 || r_bit_cnt != '0) begin
            w_abort   = 1'b1;
            w_err_inc = 1'b1;
          end
          w_byte_cnt_nxt = '0;
        end else if (w_byte_done) begin
          if (w_sync_bad) begin
            w_err_inc   = 1'b1;
            w_state_nxt = DROP;
          end else begin
            w_emit = 1'b1;
            w_sop  = (r_byte_cnt == '0);
            if (r_byte_cnt == LAST_BYTE) begin
              w_eop          = 1'b1;
              w_pkt_inc      = 1'b1;
              w_state_nxt    = HUNT;
              w_byte_cnt_nxt = '0;
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + 8'd1;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= HUNT;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh         <= '0;
      r_bit_cnt    <= '0;
      r_start_q    <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_byte_sop   <= 1'b0;
      r_byte_eop   <= 1'b0;
      r_pkt_abort  <= 1'b0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (ts.ts_valid) begin
        r_start_q <= ts.ts_start;
        r_sh      <= w_byte[6:0];
        r_bit_cnt <= w_start_edge ? 3'd1 : r_bit_cnt + 3'd1;
      end
      r_byte_valid <= w_emit;
      r_byte_sop   <= w_sop;
      r_byte_eop   <= w_eop;
      r_pkt_abort  <= w_abort;
      if (w_emit) begin
        r_byte_data <= w_byte;
      end
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign ts.byte_data  = r_byte_data;
  assign ts.byte_valid = r_byte_valid;
  assign ts.byte_sop   = r_byte_sop;
  assign ts.byte_eop   = r_byte_eop;
  assign ts.pkt_abort  = r_pkt_abort;
  assign ts.pkt_cnt    = r_pkt_cnt;
  assign ts.err_cnt    = r_err_cnt;

endmodule
